// File: rtl/slice_config_loader_if.sv
// Serial configuration bus between a bitstream source and the slice loader.
//   start     : begin a load (level, sampled every cycle)
//   abort     : cancel an in-progress load
//   bit_in    : serial bitstream data
//   bit_valid : bit_in is valid this cycle
//   bit_ready : loader accepts a bit this cycle
interface slice_config_loader_if;
  logic start;
  logic abort;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (output start, abort, bit_in, bit_valid, input bit_ready);
  modport slave  (input start, abort, bit_in, bit_valid, output bit_ready);
endinterface

// File: rtl/slice_config_loader.sv
// Shifts a serial bitstream into a shadow register and commits it to a slice.
// The first accepted bit lands in the MSB of the shadow register.
//   cclk                     : configuration clock, rising edge
//   rst                      : asynchronous active-high reset
//   bus                      : serial bus (slave side), see slice_config_loader_if
//   luts_config_out          : per-LUT config, LUT i at [i*2*CFG_SIZE +: 2*CFG_SIZE]
//   inter_lut_mux_config_out : inter-LUT mux config
//   config_use_cc_out        : carry-chain select
//   cen                      : one-cycle commit strobe
//   busy                     : load in progress (SHIFT or COMMIT)
//   done                     : last load committed
module slice_config_loader #(
  parameter  int unsigned S_XX_BASE = 4,
  parameter  int unsigned NUM_LUTS  = 4,
  localparam int unsigned CFG_SIZE  = 2**S_XX_BASE + 1,
  localparam int unsigned MUX_LVLS  = $clog2(NUM_LUTS),
  localparam int unsigned LUT_W     = NUM_LUTS * 2 * CFG_SIZE,
  localparam int unsigned TOTAL     = LUT_W + MUX_LVLS + 1
) (
  input  logic                      cclk,
  input  logic                      rst,
  slice_config_loader_if.slave      bus,
  output logic [LUT_W-1:0]          luts_config_out,
  output logic [MUX_LVLS-1:0]       inter_lut_mux_config_out,
  output logic                      config_use_cc_out,
  output logic                      cen,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TOTAL-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               cen_q, cen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State, shadow register and registered status outputs.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      cen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      cen_q   <= cen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, shift and counter logic; status outputs decode the next state
  // so their registered copies line up with the state they describe.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // abort wins over a valid bit: no shift on the abort cycle
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.bit_valid) begin
          sh_d  = {sh_q[TOTAL-2:0], bus.bit_in};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TOTAL - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == SHIFT);
    cen_d   = (state_d == COMMIT);
    busy_d  = (state_d == SHIFT) || (state_d == COMMIT);
    done_d  = (state_d == DONE);
  end

  assign bus.bit_ready                = ready_q;
  assign cen                          = cen_q;
  assign busy                         = busy_q;
  assign done                         = done_q;

  assign luts_config_out              = sh_q[LUT_W-1:0];
  assign inter_lut_mux_config_out     = sh_q[LUT_W +: MUX_LVLS];
  assign config_use_cc_out            = sh_q[TOTAL-1];

endmodule

// File: tb/tb_slice_config_loader.sv
// Directed self-checking bench for slice_config_loader (default parameters).
module tb_slice_config_loader;

  localparam int unsigned W  = 139;
  localparam int unsigned LW = 136;

  logic          cclk;
  logic          rst;
  logic [LW-1:0] luts;
  logic [1:0]    mux;
  logic          cc;
  logic          cen;
  logic          busy;
  logic          done;

  int checks;
  int errors;
  int cen_cnt;
  int exp_cen;

  slice_config_loader_if ifc ();

  slice_config_loader dut (
    .cclk                     (cclk),
    .rst                      (rst),
    .bus                      (ifc.slave),
    .luts_config_out          (luts),
    .inter_lut_mux_config_out (mux),
    .config_use_cc_out        (cc),
    .cen                      (cen),
    .busy                     (busy),
    .done                     (done)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  // Count commit strobes away from the active edge.
  always @(negedge cclk) begin
    if (cen) cen_cnt++;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  // Full shadow register as seen on the outputs.
  function automatic logic [W-1:0] sh_now();
    return {cc, mux, luts};
  endfunction

  // One complete load; vec ends up in the shadow register unchanged.
  task automatic do_load(input logic [W-1:0] vec, input bit toggle, input bit hold);
    ifc.start = 1'b1;
    tick();
    if (!hold) ifc.start = 1'b0;
    check("shift_busy",  W'(busy),          W'(1));
    check("shift_ready", W'(ifc.bit_ready), W'(1));
    check("shift_done",  W'(done),          W'(0));
    for (int i = 0; i < int'(W); i++) begin
      ifc.bit_valid = 1'b1;
      ifc.bit_in    = vec[int'(W) - 1 - i];
      tick();
      if (toggle && i != int'(W) - 1) begin
        ifc.bit_valid = 1'b0;
        tick();
      end
    end
    // keep a valid 1 on the bus through COMMIT; it must be ignored
    ifc.bit_valid = 1'b1;
    ifc.bit_in    = 1'b1;
    exp_cen++;
    check("commit_cen",   W'(cen),           W'(1));
    check("commit_ready", W'(ifc.bit_ready), W'(0));
    check("commit_busy",  W'(busy),          W'(1));
    tick();
    ifc.bit_valid = 1'b0;
    check("done_cen",   W'(cen),     W'(0));
    check("done_flag",  W'(done),    W'(1));
    check("done_busy",  W'(busy),    W'(0));
    check("cen_count",  W'(cen_cnt), W'(exp_cen));
    check("sh_loaded",  sh_now(),    vec);
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] e;
    checks  = 0;
    errors  = 0;
    cen_cnt = 0;
    exp_cen = 0;
    rst           = 1'b0;
    ifc.start     = 1'b0;
    ifc.abort     = 1'b0;
    ifc.bit_in    = 1'b0;
    ifc.bit_valid = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_sh",    sh_now(),        W'(0));
    check("rst_ready", W'(ifc.bit_ready), W'(0));
    check("rst_cen",   W'(cen),         W'(0));
    check("rst_busy",  W'(busy),        W'(0));
    check("rst_done",  W'(done),        W'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single leading 1: only the carry-chain select ends up set
    v = '0;
    v[W-1] = 1'b1;
    do_load(v, 1'b0, 1'b0);
    check("cc_only_cc",   W'(cc),   W'(1));
    check("cc_only_mux",  W'(mux),  W'(0));
    check("cc_only_luts", W'(luts), W'(0));

    // Valid bits in DONE are ignored
    ifc.bit_valid = 1'b1;
    ifc.bit_in    = 1'b1;
    repeat (3) tick();
    ifc.bit_valid = 1'b0;
    check("done_hold_sh",    sh_now(),          v);
    check("done_hold_ready", W'(ifc.bit_ready), W'(0));
    check("done_hold_done",  W'(done),          W'(1));

    // Last bit 1 with valid toggling: LUT 0 bit 0
    v = W'(1);
    do_load(v, 1'b1, 1'b0);
    check("lut0_bit0", W'(luts), W'(1));
    check("lut0_cc",   W'(cc),   W'(0));

    // Abort after 70 accepted ones; partial contents retained
    ifc.start = 1'b1;
    tick();
    ifc.start     = 1'b0;
    ifc.bit_valid = 1'b1;
    ifc.bit_in    = 1'b1;
    repeat (70) tick();
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
    e = '0;
    e[70:0] = '1;
    check("abort_ready", W'(ifc.bit_ready), W'(0));
    check("abort_busy",  W'(busy),          W'(0));
    check("abort_done",  W'(done),          W'(0));
    check("abort_sh",    sh_now(),          e);
    // still valid=1 while IDLE: nothing shifts
    repeat (3) tick();
    ifc.bit_valid = 1'b0;
    check("idle_hold_sh",  sh_now(),    e);
    check("abort_no_cen",  W'(cen_cnt), W'(exp_cen));

    // Fresh load with start held throughout: no restart until DONE
    v = {1'b0, 2'b10, {17{8'hA5}}};
    do_load(v, 1'b0, 1'b1);
    check("mix_mux",  W'(mux), W'(2'b10));
    check("mix_lut3", W'(luts[3*34 +: 34]), W'({34'h2_9696_9696} & 34'h3_FFFF_FFFF));
    tick();
    ifc.start = 1'b0;
    check("restart_busy",  W'(busy),          W'(1));
    check("restart_done",  W'(done),          W'(0));
    check("restart_ready", W'(ifc.bit_ready), W'(1));

    // Reset mid-SHIFT after 100 bits
    ifc.bit_valid = 1'b1;
    ifc.bit_in    = 1'b1;
    repeat (100) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_sh",    sh_now(),          W'(0));
    check("midrst_ready", W'(ifc.bit_ready), W'(0));
    check("midrst_busy",  W'(busy),          W'(0));
    check("midrst_done",  W'(done),          W'(0));
    check("midrst_cen",   W'(cen),           W'(0));
    tick();
    tick();
    // release with start already high: first edge must be honoured
    rst           = 1'b0;
    ifc.bit_valid = 1'b0;
    ifc.start     = 1'b1;
    tick();
    ifc.start = 1'b0;
    check("first_start_busy", W'(busy), W'(1));
    // no valid bits: stall indefinitely, never commit
    repeat (200) tick();
    check("stall_busy",   W'(busy),    W'(1));
    check("stall_no_cen", W'(cen_cnt), W'(exp_cen));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
